// File: rtl/mcp3008_emu.sv
// MCP3008 SPI responder: answers ADC reads with per-channel codes from ch_data, all logic in CLK50.
// Latency: MISO/MISO_oe follow a raw SCLK fall by SYNC_STAGES+1 cycles; no backpressure, master paces everything.
module mcp3008_emu #(
  parameter int N           = 10,
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK50,
  input  logic                    reset_n,
  input  logic                    SCLK,
  input  logic                    CS_n,
  input  logic                    MOSI,
  output logic                    MISO,
  output logic                    MISO_oe,
  input  logic [NCH-1:0][N-1:0]   ch_data,
  output logic                    conv_done,
  output logic [2:0]              conv_chan,
  output logic                    conv_sgl
);

  localparam int CW = ($clog2(N) < 2) ? 2 : $clog2(N);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_START = 3'd1;
  localparam logic [2:0] CMD        = 3'd2;
  localparam logic [2:0] SAMPLE     = 3'd3;
  localparam logic [2:0] NULLB      = 3'd4;
  localparam logic [2:0] DATA       = 3'd5;
  localparam logic [2:0] TRAIL      = 3'd6;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [N-1:0]           sample_q, sample_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   conv_done_q, conv_done_d;
  logic [2:0]             conv_chan_q, conv_chan_d;
  logic                   conv_sgl_q, conv_sgl_d;

  logic         sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
  logic [3:0]   cmd_full;
  logic [N-1:0] sel_code;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cmd_full  = {cmd_q[2:0], mosi_s};

  // Channels at or above NCH read as zero.
  always_comb begin
    sel_code = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(cmd_full[2:0]) == i) sel_code = ch_data[i];
    end
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    sample_d    = sample_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    conv_done_d = 1'b0;
    conv_chan_d = conv_chan_q;
    conv_sgl_d  = conv_sgl_q;

    // Deselect overrides any SCLK edge seen in the same cycle.
    if (state_q != IDLE && cs_s) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          if (!cs_s) state_d = WAIT_START;
        end
        WAIT_START: begin
          if (sclk_rise && mosi_s) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_d = cmd_full;
            if (cnt_q == CW'(3)) begin
              sample_d = cmd_full[3] ? sel_code : '0;
              state_d  = SAMPLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        SAMPLE: begin
          if (sclk_rise) state_d = NULLB;
        end
        NULLB: begin
          if (sclk_fall) begin
            miso_oe_d = 1'b1;
            miso_d    = 1'b0;
            cnt_d     = CW'(N-1);
            state_d   = DATA;
          end
        end
        DATA: begin
          if (sclk_fall) begin
            miso_d = sample_q[cnt_q];
            if (cnt_q == '0) begin
              conv_done_d = 1'b1;
              conv_chan_d = cmd_q[2:0];
              conv_sgl_d  = cmd_q[3];
              state_d     = TRAIL;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        TRAIL: begin
          if (sclk_fall) miso_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK50 or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      sample_q    <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      conv_done_q <= 1'b0;
      conv_chan_q <= '0;
      conv_sgl_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      sample_q    <= sample_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      conv_done_q <= conv_done_d;
      conv_chan_q <= conv_chan_d;
      conv_sgl_q  <= conv_sgl_d;
    end
  end

  assign MISO      = miso_q;
  assign MISO_oe   = miso_oe_q;
  assign conv_done = conv_done_q;
  assign conv_chan = conv_chan_q;
  assign conv_sgl  = conv_sgl_q;

endmodule

// File: tb/tb_mcp3008_emu.sv
// Bench for mcp3008_emu: SPI master driver plus scoreboard monitors on two instances (NCH=8 and NCH=2).
module tb_mcp3008_emu;

  localparam int N    = 10;
  localparam int S    = 2;
  localparam int HALF = 16;

  typedef struct packed {
    logic [N-1:0] code;
    logic [2:0]   chan;
    logic         sgl;
  } exp_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic              rst_n, sclk, cs_n, mosi;
  logic [7:0][N-1:0] chd;
  logic              miso0, oe0, done0, sgl0;
  logic [2:0]        chan0;
  logic              miso1, oe1, done1, sgl1;
  logic [2:0]        chan1;

  mcp3008_emu #(.N(N), .NCH(8), .SYNC_STAGES(S)) u_dut0 (
    .CLK50(clk), .reset_n(rst_n), .SCLK(sclk), .CS_n(cs_n), .MOSI(mosi),
    .MISO(miso0), .MISO_oe(oe0), .ch_data(chd),
    .conv_done(done0), .conv_chan(chan0), .conv_sgl(sgl0)
  );

  mcp3008_emu #(.N(N), .NCH(2), .SYNC_STAGES(S)) u_dut1 (
    .CLK50(clk), .reset_n(rst_n), .SCLK(sclk), .CS_n(cs_n), .MOSI(mosi),
    .MISO(miso1), .MISO_oe(oe1), .ch_data(chd[1:0]),
    .conv_done(done1), .conv_chan(chan1), .conv_sgl(sgl1)
  );

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_exp = 0;
  int          n_done0 = 0;
  int          n_done1 = 0;
  logic [8:0]  sh0 = '0;
  logic [8:0]  sh1 = '0;
  logic [23:0] rx;
  int          oe_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [N-1:0] model(input logic [2:0] ch, input logic sgl, input int nch);
    if (sgl && int'(ch) < nch) return chd[ch];
    return '0;
  endfunction

  // Master-view shift registers: MISO as seen on each SCLK rise.
  always @(posedge sclk) begin
    sh0 <= {sh0[7:0], miso0};
    sh1 <= {sh1[7:0], miso1};
  end

  // B0 is on MISO during the conv_done cycle; B9..B1 are already in the shifters.
  always @(negedge clk) begin
    if (done0) begin
      n_done0++;
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL dut0 conv_done with no transaction outstanding: chan=%0d", chan0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 code", {sh0, miso0}, e0.code);
        chk("dut0 conv_chan", chan0, e0.chan);
        chk("dut0 conv_sgl", sgl0, e0.sgl);
      end
    end
    if (done1) begin
      n_done1++;
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL dut1 conv_done with no transaction outstanding: chan=%0d", chan1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 code", {sh1, miso1}, e1.code);
        chk("dut1 conv_chan", chan1, e1.chan);
        chk("dut1 conv_sgl", sgl1, e1.sgl);
      end
    end
  end

  // abort_at: rise after whose fall CS_n is raised (0 = full transfer).
  // chg_at: rise at which ch_data[0] is replaced by chg_val (0 = never).
  task automatic spi_xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int abort_at, input bit do_rst,
                          input int chg_at, input logic [N-1:0] chg_val,
                          output logic [23:0] rx_o, output int oe_err_o);
    logic [23:0] tx;
    exp_t        t;
    tx       = {b0, b1, b2};
    rx_o     = '0;
    oe_err_o = 0;
    if (abort_at == 0) begin
      t.chan = b1[6:4];
      t.sgl  = b1[7];
      t.code = model(b1[6:4], b1[7], 8);
      q0.push_back(t);
      t.code = model(b1[6:4], b1[7], 2);
      q1.push_back(t);
      n_exp++;
    end
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int r = 1; r <= 24; r++) begin
      mosi = tx[24-r];
      wait_clks(HALF);
      rx_o = {rx_o[22:0], miso0};
      if (oe0 !== (r >= 14)) oe_err_o++;
      sclk = 1'b1;
      if (r == chg_at) chd[0] = chg_val;
      wait_clks(HALF);
      sclk = 1'b0;
      if (r == abort_at) begin
        wait_clks(S + 3);
        if (do_rst) begin
          rst_n = 1'b0;
          #1;
          chk("reset mid-DATA dut0 outputs", {miso0, oe0, done0, chan0, sgl0}, 0);
          chk("reset mid-DATA dut1 outputs", {miso1, oe1, done1, chan1, sgl1}, 0);
          wait_clks(2);
          cs_n = 1'b1;
          wait_clks(2);
          rst_n = 1'b1;
        end else begin
          chk("abort MISO_oe before CS_n rise", {oe0, oe1}, 2'b11);
          cs_n = 1'b1;
          wait_clks(S + 2);
          chk("abort MISO_oe after CS_n rise", {oe0, oe1, miso0, miso1}, 0);
        end
        wait_clks(HALF);
        return;
      end
    end
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(HALF);
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    chd   = '0;
    wait_clks(3);
    chk("reset dut0 outputs", {miso0, oe0, done0, chan0, sgl0}, 0);
    chk("reset dut1 outputs", {miso1, oe1, done1, chan1, sgl1}, 0);
    rst_n = 1'b1;
    wait_clks(4);

    chd[1] = 10'h2A5;
    spi_xfer(8'h01, 8'h90, 8'h00, 0, 1'b0, 0, '0, rx, oe_err);
    chk("ch1 byte2 null+B9B8", rx[10:8], 3'b010);
    chk("ch1 byte3", rx[7:0], 8'hA5);
    chk("ch1 MISO_oe window", oe_err, 0);

    chd[0] = 10'h000; chd[1] = 10'h3FF; chd[2] = 10'h155; chd[3] = 10'h2AA;
    chd[4] = 10'h001; chd[5] = 10'h200; chd[6] = 10'h0F0; chd[7] = 10'h30F;
    for (int c = 0; c < 8; c++) begin
      spi_xfer(8'h01, {1'b1, 3'(c), 4'h0}, 8'h00, 0, 1'b0, 0, '0, rx, oe_err);
      chk("sweep byte3", rx[7:0], chd[c][7:0]);
    end

    chd[0] = 10'h123;
    spi_xfer(8'h01, 8'h80, 8'h00, 0, 1'b0, 13, 10'h321, rx, oe_err);
    spi_xfer(8'h01, 8'h80, 8'h00, 0, 1'b0, 0, '0, rx, oe_err);

    spi_xfer(8'h01, 8'hA0, 8'h00, 18, 1'b0, 0, '0, rx, oe_err);
    spi_xfer(8'h01, 8'hA0, 8'h00, 0, 1'b0, 0, '0, rx, oe_err);

    spi_xfer(8'h01, 8'h30, 8'h00, 0, 1'b0, 0, '0, rx, oe_err);
    spi_xfer(8'h01, 8'hD0, 8'h00, 0, 1'b0, 0, '0, rx, oe_err);

    spi_xfer(8'h01, 8'hB0, 8'h00, 18, 1'b1, 0, '0, rx, oe_err);
    spi_xfer(8'h01, 8'hF0, 8'h00, 0, 1'b0, 0, '0, rx, oe_err);

    wait_clks(20);
    chk("dut0 expectations drained", q0.size(), 0);
    chk("dut1 expectations drained", q1.size(), 0);
    chk("dut0 conv_done pulse count", n_done0, n_exp);
    chk("dut1 conv_done pulse count", n_done1, n_exp);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mcp3008_emu.md
Name: mcp3008_emu

Overview:
- Synthesizable SPI responder that emulates an MCP3008 8-channel 10-bit ADC. It runs in the CLK50 domain.
- It answers the same SPI transactions our ADC master issues, so the master and the filter path can be loop-tested on the FPGA with known per-channel codes instead of live potentiometers.
- SCLK/CS_n/MOSI are asynchronous inputs. They are synchronized and edge-detected internally; the block never clocks on SCLK.

Parameters:
- N, 10, ADC code width.
- NCH, 8, number of emulated channels (1..8).
- SYNC_STAGES, 2, flops per input synchronizer (>=2).

Ports:
- CLK50  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- SCLK  input  1  SPI clock from master (idle low, mode 0,0).
- CS_n  input  1  chip select from master, active low.
- MOSI  input  1  command bit from master (DIN).
- MISO  output  1  data bit to master (DOUT); 0 whenever MISO_oe=0.
- MISO_oe  output  1  1 = DOUT driven; the top level tri-states the pin when 0.
- ch_data  input  [NCH-1:0][N-1:0]  code returned per channel.
- conv_done  output  1  one-CLK50 pulse after B0 is driven.
- conv_chan  output  3  channel field {D2,D1,D0} of the last completed conversion.
- conv_sgl  output  1  SGL/DIFF bit of the last completed conversion.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, MISO=0, MISO_oe=0, conv_done=0, conv_chan=0, conv_sgl=0, bit counter=0, latched sample=0. Synchronizers reset to SCLK=0, CS_n=1, MOSI=0.
- Input conditioning:
  - SCLK, CS_n and MOSI each pass through SYNC_STAGES flops.
  - Rise/fall detection compares the last two synchronized SCLK values.
  - MOSI is taken from the same sync stage as SCLK, so the bit is aligned with the detected edge.
  - Requirement on the master: SCLK high and low times are each >= SYNC_STAGES+3 CLK50 cycles. The master's 256-cycle SCLK period meets this.
- Edge convention: MOSI is sampled on SCLK rise; MISO changes on SCLK fall, MSB first.
- States:
  - IDLE: MISO_oe=0. Go to WAIT_START when synced CS_n=0.
  - WAIT_START: each SCLK rise with MOSI=0 is ignored (leading zeros are allowed). A rise with MOSI=1 goes to CMD with count=0.
  - CMD: 4 rises capture SGL, D2, D1, D0 in that order. On the D0 rise:
    - Latch sample = ch_data[{D2,D1,D0}] if SGL=1 and {D2,D1,D0}<NCH; otherwise latch 0. Differential mode is not emulated.
    - Go to SAMPLE.
  - SAMPLE: the next SCLK rise (sample period end) goes to NULLB.
  - NULLB: the next SCLK fall sets MISO_oe=1, MISO=0 (null bit), count=N-1, then goes to DATA.
  - DATA: each SCLK fall drives MISO=sample[count].
    - The fall that drives bit 0 pulses conv_done for one cycle and updates conv_chan/conv_sgl from the captured command. It then goes to TRAIL.
    - count decrements otherwise.
  - TRAIL: MISO=0 on further falls. MISO_oe stays 1 until CS_n rises.
- CS_n rise (synced) in any state: go to IDLE next cycle, MISO_oe=0, MISO=0.
  - If this aborts before the B0 fall, there is no conv_done pulse and conv_chan/conv_sgl keep their old values.
  - If CS_n rises and SCLK has an edge in the same cycle, CS_n wins and the edge is ignored.
- ch_data may change at any time. Only the value present at the D0 rise is returned, so the code is frozen for the whole transaction.
- Latency: MISO/MISO_oe update at SYNC_STAGES+2 CLK50 cycles or less after the raw SCLK fall. conv_done asserts in the same cycle MISO takes B0.
- Back-to-back transactions: a new CS_n fall restarts from WAIT_START. There is no minimum CS_n high time beyond the sync delay.
- Transaction with 24 rises (0x01, 0x80|ch<<4, 0x00): the start bit is sampled on rise 8, D0 on rise 12, the null bit falls after rise 13, B9..B0 on the falls after rises 14..23.

Test Plan:
- Reset, then bench SPI driver sends 0x01,0x90,0x00 with ch_data[1]=10'h2A5 -> master-view bytes read 0x??, 0x?2 (low 2 bits = 2'b10), 0xA5; one conv_done pulse; conv_chan=1; conv_sgl=1; MISO_oe=1 from the null fall until CS_n rises.
- Channels 0..7 loaded 10'h000, 10'h3FF, 10'h155, 10'h2AA, 10'h001, 10'h200, 10'h0F0, 10'h30F; sweep all channels back-to-back -> every returned code matches; 8 conv_done pulses.
- Change ch_data[0] from 10'h123 to 10'h321 one SCLK after the D0 rise -> 10'h123 returned; next transaction returns 10'h321.
- Raise CS_n after 5 of 10 data bits -> no conv_done; MISO_oe=0 within SYNC_STAGES+2 cycles; the next full transaction returns the correct code.
- SGL=0 command, and with NCH=2 a channel 5 request -> both return 10'h000; conv_done pulses with conv_sgl=0 and conv_chan=5 respectively.
- Assert reset_n=0 mid-DATA -> all outputs 0 immediately; after release, the next transaction is correct. Connect to the team ADC master: adc_out[0]/[1] equal ch_data[0]/[1].
